kamus_wb: RTL and testbench

Writeback stage of the kamus pipeline: holds the MEM/WB pipeline register, selects the final register-file write data from the MEM stage results, and drives the register-file write port. It also provides a WB-stage forwarding source for the EX bypass network and retired-instruction and taken-branch counters. It sits directly downstream of the MEM stage and consumes its outputs (write enable, ALU result, load data, next PC, rd address, mux select, branch-taken).

---
 rtl/kamus_wb.sv | 139 +++++++++++++
 tb/tb_kamus_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/kamus_wb.sv
// Writeback stage: MEM/WB pipeline register, final write-data select, register-file
// write port, WB-stage forwarding source and retire/taken-branch counters.
module kamus_wb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             regfile_wr_en_i,
    input  logic [XLEN-1:0]  ex_rslt_i,
    input  logic [XLEN-1:0]  l1d_rd_data_i,
    input  logic [XLEN-1:0]  next_pc_i,
    input  logic [4:0]       rd_addr_i,
    input  logic [1:0]       wb_mux_sel_i,
    input  logic             is_branch_taken_i,
    output logic             rf_wr_en_o,
    output logic [4:0]       rf_wr_addr_o,
    output logic [XLEN-1:0]  rf_wr_data_o,
    output logic             fwd_valid_o,
    output logic [4:0]       fwd_rd_addr_o,
    output logic [XLEN-1:0]  fwd_data_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] branch_cnt_o
);

    localparam int unsigned RA_W  = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_ALU  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_LOAD = 2'b01;
    localparam logic [SEL_W-1:0] SEL_PC   = 2'b10;

    logic             valid_q,     valid_d;
    logic             wr_en_q,     wr_en_d;
    logic [RA_W-1:0]  rd_addr_q,   rd_addr_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic [XLEN-1:0]  ex_rslt_q,   ex_rslt_d;
    logic [XLEN-1:0]  ld_data_q,   ld_data_d;
    logic [XLEN-1:0]  next_pc_q,   next_pc_d;
    logic             br_taken_q,  br_taken_d;
    logic             done_q,      done_d;
    logic [CNT_W-1:0] instret_q,   instret_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

    logic             retire;
    logic             wr_ok;
    logic [XLEN-1:0]  wr_data;

    // MEM/WB capture; done marks an instruction that already retired while stalled
    always_comb begin
        valid_d    = valid_q;
        wr_en_d    = wr_en_q;
        rd_addr_d  = rd_addr_q;
        sel_d      = sel_q;
        ex_rslt_d  = ex_rslt_q;
        ld_data_d  = ld_data_q;
        next_pc_d  = next_pc_q;
        br_taken_d = br_taken_q;
        done_d     = done_q;
        if (rst_i) begin
            valid_d    = 1'b0;
            wr_en_d    = 1'b0;
            rd_addr_d  = '0;
            sel_d      = '0;
            ex_rslt_d  = '0;
            ld_data_d  = '0;
            next_pc_d  = '0;
            br_taken_d = 1'b0;
            done_d     = 1'b0;
        end else if (stall_i) begin
            done_d = done_q | valid_q;
        end else begin
            valid_d    = valid_i & ~flush_i;
            wr_en_d    = regfile_wr_en_i;
            rd_addr_d  = rd_addr_i;
            sel_d      = wb_mux_sel_i;
            ex_rslt_d  = ex_rslt_i;
            ld_data_d  = l1d_rd_data_i;
            next_pc_d  = next_pc_i;
            br_taken_d = is_branch_taken_i;
            done_d     = 1'b0;
        end
    end

    // Retire and taken-branch counters wrap freely
    always_comb begin
        instret_d    = instret_q;
        branch_cnt_d = branch_cnt_q;
        if (rst_i) begin
            instret_d    = '0;
            branch_cnt_d = '0;
        end else if (retire) begin
            instret_d = instret_q + CNT_W'(1);
            if (br_taken_q) begin
                branch_cnt_d = branch_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        valid_q      <= valid_d;
        wr_en_q      <= wr_en_d;
        rd_addr_q    <= rd_addr_d;
        sel_q        <= sel_d;
        ex_rslt_q    <= ex_rslt_d;
        ld_data_q    <= ld_data_d;
        next_pc_q    <= next_pc_d;
        br_taken_q   <= br_taken_d;
        done_q       <= done_d;
        instret_q    <= instret_d;
        branch_cnt_q <= branch_cnt_d;
    end

    always_comb begin
        wr_data = ex_rslt_q;
        case (sel_q)
            SEL_ALU:  wr_data = ex_rslt_q;
            SEL_LOAD: wr_data = ld_data_q;
            SEL_PC:   wr_data = next_pc_q;
            default:  wr_data = ex_rslt_q;
        endcase
    end

    assign retire = valid_q & ~done_q;
    assign wr_ok  = valid_q & wr_en_q & (rd_addr_q != RA_W'(0));

    assign rf_wr_en_o    = wr_ok & ~done_q;
    assign rf_wr_addr_o  = rd_addr_q;
    assign rf_wr_data_o  = wr_data;
    assign fwd_valid_o   = wr_ok;
    assign fwd_rd_addr_o = rd_addr_q;
    assign fwd_data_o    = wr_data;
    assign instret_o     = instret_q;
    assign branch_cnt_o  = branch_cnt_q;

endmodule

// File: tb/tb_kamus_wb.sv
// Directed self-checking bench for kamus_wb; a second CNT_W=4 instance checks counter wrap.
module tb_kamus_wb;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush, wr_en, br;
    logic [31:0] ex, ld, pc;
    logic [4:0]  rd;
    logic [1:0]  sel;

    logic        rf_wr_en, fwd_valid;
    logic [4:0]  rf_wr_addr, fwd_rd_addr;
    logic [31:0] rf_wr_data, fwd_data;
    logic [63:0] instret, branch_cnt;

    logic        rf_wr_en4, fwd_valid4;
    logic [4:0]  rf_wr_addr4, fwd_rd_addr4;
    logic [31:0] rf_wr_data4, fwd_data4;
    logic [3:0]  instret4, branch_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    kamus_wb #(.XLEN(32), .CNT_W(64)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .regfile_wr_en_i(wr_en), .ex_rslt_i(ex), .l1d_rd_data_i(ld), .next_pc_i(pc),
        .rd_addr_i(rd), .wb_mux_sel_i(sel), .is_branch_taken_i(br),
        .rf_wr_en_o(rf_wr_en), .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data),
        .fwd_valid_o(fwd_valid), .fwd_rd_addr_o(fwd_rd_addr), .fwd_data_o(fwd_data),
        .instret_o(instret), .branch_cnt_o(branch_cnt)
    );

    kamus_wb #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .stall_i(stall), .flush_i(flush),
        .regfile_wr_en_i(wr_en), .ex_rslt_i(ex), .l1d_rd_data_i(ld), .next_pc_i(pc),
        .rd_addr_i(rd), .wb_mux_sel_i(sel), .is_branch_taken_i(br),
        .rf_wr_en_o(rf_wr_en4), .rf_wr_addr_o(rf_wr_addr4), .rf_wr_data_o(rf_wr_data4),
        .fwd_valid_o(fwd_valid4), .fwd_rd_addr_o(fwd_rd_addr4), .fwd_data_o(fwd_data4),
        .instret_o(instret4), .branch_cnt_o(branch_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic we, input logic [4:0] r, input logic [1:0] s,
                       input logic [31:0] e, input logic [31:0] l, input logic [31:0] p,
                       input logic b);
        valid = v; wr_en = we; rd = r; sel = s; ex = e; ld = l; pc = p; br = b;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        check("rst_wr_en", 64'(rf_wr_en), 64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_wr_data", 64'(rf_wr_data), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_branch_cnt", branch_cnt, 64'd0);

        // Basic ALU writeback
        drv(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        check("alu_wr_en", 64'(rf_wr_en), 64'd1);
        check("alu_wr_addr", 64'(rf_wr_addr), 64'd5);
        check("alu_wr_data", 64'(rf_wr_data), 64'h1234_5678);
        check("alu_fwd_valid", 64'(fwd_valid), 64'd1);
        check("alu_fwd_addr", 64'(fwd_rd_addr), 64'd5);
        check("alu_fwd_data", 64'(fwd_data), 64'h1234_5678);
        check("alu_instret_lat", instret, 64'd0);
        tick();
        check("alu_instret", instret, 64'd1);
        check("alu_idle_wr_en", 64'(rf_wr_en), 64'd0);

        // Mux coverage, back to back
        drv(1'b1, 1'b1, 5'd6, 2'b01, 32'h1, 32'hFFFF_FF80, 32'h2, 1'b0);
        tick();
        check("mux01_data", 64'(rf_wr_data), 64'hFFFF_FF80);
        drv(1'b1, 1'b1, 5'd7, 2'b10, 32'h1, 32'h3, 32'h0000_0104, 1'b0);
        tick();
        check("mux10_data", 64'(rf_wr_data), 64'h104);
        drv(1'b1, 1'b1, 5'd8, 2'b11, 32'hA, 32'h5, 32'h7, 1'b0);
        tick();
        check("mux11_data", 64'(rf_wr_data), 64'hA);
        idle();
        tick();
        check("mux_instret", instret, 64'd4);

        // x0 suppression
        drv(1'b1, 1'b1, 5'd0, 2'b00, 32'hDEAD, 32'h0, 32'h0, 1'b0);
        tick();
        idle();
        check("x0_wr_en", 64'(rf_wr_en), 64'd0);
        check("x0_fwd_valid", 64'(fwd_valid), 64'd0);
        check("x0_wr_data", 64'(rf_wr_data), 64'hDEAD);
        tick();
        check("x0_instret", instret, 64'd5);

        // Stall: write once, forward for all held cycles, count once
        drv(1'b1, 1'b1, 5'd3, 2'b00, 32'h55, 32'h0, 32'h0, 1'b0);
        tick();
        check("stall_c0_wr_en", 64'(rf_wr_en), 64'd1);
        check("stall_c0_fwd", 64'(fwd_valid), 64'd1);
        drv(1'b1, 1'b1, 5'd7, 2'b00, 32'h99, 32'h0, 32'h0, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_c%0d_wr_en", i + 1), 64'(rf_wr_en), 64'd0);
            check($sformatf("stall_c%0d_fwd", i + 1), 64'(fwd_valid), 64'd1);
            check($sformatf("stall_c%0d_addr", i + 1), 64'(fwd_rd_addr), 64'd3);
            check($sformatf("stall_c%0d_data", i + 1), 64'(fwd_data), 64'h55);
            check($sformatf("stall_c%0d_instret", i + 1), instret, 64'd6);
        end
        idle();
        tick();
        check("stall_end_instret", instret, 64'd6);
        check("stall_end_branch", branch_cnt, 64'd0);
        check("stall_end_fwd", 64'(fwd_valid), 64'd0);

        // Flush kills a taken branch
        drv(1'b1, 1'b1, 5'd9, 2'b00, 32'h77, 32'h0, 32'h0, 1'b1);
        flush = 1'b1;
        tick();
        idle();
        check("flush_wr_en", 64'(rf_wr_en), 64'd0);
        check("flush_fwd", 64'(fwd_valid), 64'd0);
        tick();
        check("flush_instret", instret, 64'd6);
        check("flush_branch", branch_cnt, 64'd0);

        // Same branch without flush
        drv(1'b1, 1'b1, 5'd9, 2'b00, 32'h77, 32'h0, 32'h0, 1'b1);
        tick();
        idle();
        check("br_wr_en", 64'(rf_wr_en), 64'd1);
        tick();
        check("br_branch", branch_cnt, 64'd1);
        check("br_instret", instret, 64'd7);

        // Stall and flush together: stall wins
        drv(1'b1, 1'b1, 5'd10, 2'b00, 32'h33, 32'h0, 32'h0, 1'b0);
        tick();
        drv(1'b1, 1'b1, 5'd12, 2'b01, 32'h0, 32'h66, 32'h0, 1'b1);
        stall = 1'b1;
        flush = 1'b1;
        tick();
        check("sf_fwd", 64'(fwd_valid), 64'd1);
        check("sf_addr", 64'(rf_wr_addr), 64'd10);
        check("sf_data", 64'(rf_wr_data), 64'h33);
        check("sf_wr_en", 64'(rf_wr_en), 64'd0);
        idle();
        tick();
        check("sf_instret", instret, 64'd8);
        check("sf_branch", branch_cnt, 64'd1);

        // Reset during a stall discards the held instruction
        drv(1'b1, 1'b1, 5'd11, 2'b00, 32'h44, 32'h0, 32'h0, 1'b1);
        tick();
        check("rs_first_wr_en", 64'(rf_wr_en), 64'd1);
        stall = 1'b1;
        rst = 1'b1;
        tick();
        check("rs_wr_en", 64'(rf_wr_en), 64'd0);
        check("rs_fwd", 64'(fwd_valid), 64'd0);
        check("rs_addr", 64'(rf_wr_addr), 64'd0);
        check("rs_data", 64'(rf_wr_data), 64'd0);
        check("rs_instret", instret, 64'd0);
        check("rs_branch", branch_cnt, 64'd0);
        rst = 1'b0;
        idle();
        tick();
        check("rs_after_instret", instret, 64'd0);
        check("rs_after_branch", branch_cnt, 64'd0);

        // Counter wrap on the 4-bit instance
        drv(1'b1, 1'b1, 5'd1, 2'b00, 32'h1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        idle();
        tick();
        check("wrap_instret4", 64'(instret4), 64'd1);
        check("wrap_instret64", instret, 64'd17);
        check("wrap_branch4", 64'(branch_cnt4), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
